mem_access_unit: RTL

- MEM-stage data-memory access controller between the EX/MEM pipeline register and the MEM/WB register.
- Turns a load/store from EX/MEM into a req/ack transaction on a variable-latency word-wide data memory.
- Stalls the pipeline while the transaction is in flight.
- Delivers aligned, sign- or zero-extended load data (rdata_o) to the MEM/WB read-data input.

---
 rtl/mem_access_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: EX/MEM load/store to req/ack memory.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int DM_ADDR_W      = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic                 stall_o,
  output logic                 err_o,
  output logic                 dm_req_o,
  output logic                 dm_we_o,
  output logic [DM_ADDR_W-1:0] dm_addr_o,
  output logic [3:0]           dm_be_o,
  output logic [31:0]          dm_wdata_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                 misalign_o,
`endif
  input  logic                 dm_ack_i,
  input  logic [31:0]          dm_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        acc;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        trap;
  logic [1:0]  lane;
  logic [3:0]  be_d;
  logic [31:0] wd_d;

  logic        load_q;
  logic        byte_q;
  logic        half_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] sh;
  logic [31:0] ext;

  logic        unused_addr;

  assign unused_addr = ^addr_i[31:DM_ADDR_W+2];

  assign acc     = mem_read_i | mem_write_i;
  assign is_byte = (size_i == 2'b00);
  assign is_half = (size_i == 2'b01);
  assign is_word = size_i[1];

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = (is_half & addr_i[0]) |
                (is_word & (addr_i[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Lane offset masked to natural alignment of the access size
  always_comb begin
    lane = 2'b00;
    be_d = 4'b1111;
    wd_d = wdata_i;
    unique case (1'b1)
      is_byte: begin
        lane = addr_i[1:0];
        be_d = 4'b0001 << addr_i[1:0];
        wd_d = {4{wdata_i[7:0]}};
      end
      is_half: begin
        lane = {addr_i[1], 1'b0};
        be_d = addr_i[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{wdata_i[15:0]}};
      end
      is_word: begin
        lane = 2'b00;
        be_d = 4'b1111;
        wd_d = wdata_i;
      end
      default: begin
        lane = 2'b00;
        be_d = 4'b1111;
        wd_d = wdata_i;
      end
    endcase
  end

  // Align the returned word to the captured lane and extend
  always_comb begin
    sh  = dm_rdata_i >> {lane_q, 3'b000};
    ext = sh;
    unique case (1'b1)
      byte_q: ext = uns_q ? {24'b0, sh[7:0]}
                          : {{24{sh[7]}}, sh[7:0]};
      half_q: ext = uns_q ? {16'b0, sh[15:0]}
                          : {{16{sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  // Freeze upstream while an access is requested or in flight
  always_comb begin
    stall_o = 1'b0;
    if (state == S_WAIT)
      stall_o = 1'b1;
    else if (state == S_IDLE)
      stall_o = acc;
  end

  // Access FSM, registered memory port and load data
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
      dm_req_o   <= 1'b0;
      dm_we_o    <= 1'b0;
      dm_addr_o  <= '0;
      dm_be_o    <= '0;
      dm_wdata_o <= '0;
      load_q     <= 1'b0;
      byte_q     <= 1'b0;
      half_q     <= 1'b0;
      uns_q      <= 1'b0;
      lane_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (acc) begin
            if (trap) begin
              rdata_o <= '0;
              state   <= S_DONE;
            end else begin
              dm_req_o   <= 1'b1;
              dm_we_o    <= mem_write_i;
              dm_addr_o  <= addr_i[DM_ADDR_W+1:2];
              dm_be_o    <= be_d;
              dm_wdata_o <= wd_d;
              load_q     <= mem_read_i;
              byte_q     <= is_byte;
              half_q     <= is_half;
              uns_q      <= unsigned_i;
              lane_q     <= lane;
              state      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dm_ack_i) begin
            dm_req_o <= 1'b0;
            if (load_q)
              rdata_o <= ext;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            dm_req_o <= 1'b0;
            err_o    <= 1'b1;
            rdata_o  <= '0;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle flag that lands in DONE after a trapped access
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      misalign_o <= 1'b0;
    else
      misalign_o <= (state == S_IDLE) & acc & trap;
  end
`endif

endmodule
